// File: rtl/pwm_pkg.sv
// Shared definitions for the PI loop PWM stage: data widths, FSM state
// names and the duty clamp that the PI stage and the PWM driver both use.
package pwm_pkg;
  localparam int PI_W  = 16;
  localparam int CNT_W = 8;

  typedef logic signed [PI_W-1:0] pi_t;
  typedef logic [CNT_W-1:0]       duty_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pwm_state_e;

  typedef struct packed {
    logic  sat;
    duty_t duty;
  } clamp_t;

  // Limit a signed PI result to 0..limit; the compare is done one bit wider
  // than the input so the largest positive PI value cannot wrap negative.
  function automatic clamp_t clamp_duty(input pi_t val, input duty_t limit);
    logic signed [PI_W:0] v;
    logic signed [PI_W:0] lim;
    clamp_t r;
    v   = {val[PI_W-1], val};
    lim = {{(PI_W+1-CNT_W){1'b0}}, limit};
    if (v[PI_W]) begin
      r.sat  = 1'b1;
      r.duty = '0;
    end else if (v > lim) begin
      r.sat  = 1'b1;
      r.duty = limit;
    end else begin
      r.sat  = 1'b0;
      r.duty = val[CNT_W-1:0];
    end
    return r;
  endfunction
endpackage

// File: rtl/pi_pwm_driver_if.sv
// Bus between the PI controller side and the PWM driver: run request,
// PI result handshake, and the PWM status/drive outputs.
interface pi_pwm_driver_if;
  import pwm_pkg::*;

  logic  en;
  pi_t   pi_result;
  logic  pi_valid;
  logic  sample_req;
  logic  pwm_hi;
  logic  pwm_lo;
  duty_t duty_active;
  logic  sat;

  modport master (
    output en, pi_result, pi_valid,
    input  sample_req, pwm_hi, pwm_lo, duty_active, sat
  );

  modport slave (
    input  en, pi_result, pi_valid,
    output sample_req, pwm_hi, pwm_lo, duty_active, sat
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Splits the raw PWM into complementary high/low drives. Each output only
// asserts once its raw level has held for more than DEADTIME cycles, which
// gives DEADTIME both-low cycles after every edge and swallows short pulses.
module pwm_deadtime_gen #(
  parameter int CNT_W    = 8,
  parameter int DEADTIME = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic raw,
  output logic pwm_hi,
  output logic pwm_lo
);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(DEADTIME + 1);

  logic             prev_raw;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len;

  // Cycles the current raw level has persisted, saturating at HOLD
  always_comb begin
    len = CNT_W'(1);
    if (len_q != '0 && raw == prev_raw)
      len = (len_q == HOLD) ? HOLD : len_q + 1'b1;
  end

  // Remember last level and run length; an inactive cycle breaks the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_raw <= 1'b0;
      len_q    <= '0;
    end else begin
      prev_raw <= raw;
      len_q    <= active ? len : '0;
    end
  end

  assign pwm_hi = active &&  raw && (len == HOLD);
  assign pwm_lo = active && !raw && (len == HOLD);
endmodule

// File: rtl/pi_pwm_driver.sv
// PWM output stage of the PI loop. Clamps each PI result into a shadow
// register, applies it at period boundaries and paces the PI controller
// with a sample_req pulse at the start of every running period.
// Optional feature: define PWM_DEADTIME_EN to route the raw PWM through
// pwm_deadtime_gen; otherwise pwm_lo is the plain complement while running.
module pi_pwm_driver import pwm_pkg::*; #(
  parameter int PERIOD   = 10,
  parameter int DEADTIME = 2
) (
  input logic            clk,
  input logic            rst,
  pi_pwm_driver_if.slave bus
);
  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DRAIN = ST_DRAIN;

  localparam duty_t PERIOD_D = duty_t'(PERIOD);
  localparam duty_t LAST     = duty_t'(PERIOD - 1);

  if (PERIOD < 2 || PERIOD > (1 << CNT_W) - 1 || DEADTIME < 0) begin : g_bad_params
    $error("pi_pwm_driver: PERIOD or DEADTIME out of range");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  duty_t      cnt;
  duty_t      shadow;
  duty_t      duty_active;
  duty_t      shadow_nxt;
  logic       sat;
  logic       pwm_raw;
  logic       pwm_act;
  logic       running;
  logic       wrap;
  clamp_t     clamp;

  // A result arriving on the load cycle bypasses the shadow register
  assign clamp      = clamp_duty(bus.pi_result, PERIOD_D);
  assign shadow_nxt = bus.pi_valid ? clamp.duty : shadow;
  assign running    = (state != IDLE);
  assign wrap       = running && (cnt == LAST);

  // Run/drain sequencing; a drain can be cancelled without touching cnt
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = DRAIN;
      DRAIN:   if (bus.en) state_nxt = RUN;
               else if (wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, period counter, shadow/active duty and registered raw PWM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shadow      <= '0;
      duty_active <= '0;
      sat         <= 1'b0;
      pwm_raw     <= 1'b0;
      pwm_act     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.pi_valid) begin
        shadow <= clamp.duty;
        sat    <= clamp.sat;
      end
      if (!running || wrap) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      if (wrap || (state == IDLE && bus.en))
        duty_active <= shadow_nxt;
      pwm_act <= running;
      pwm_raw <= running && (cnt < duty_active);
    end
  end

  assign bus.sample_req  = (state == RUN) && (cnt == '0);
  assign bus.duty_active = duty_active;
  assign bus.sat         = sat;

`ifdef PWM_DEADTIME_EN
  pwm_deadtime_gen #(
    .CNT_W    (CNT_W),
    .DEADTIME (DEADTIME)
  ) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .active (pwm_act),
    .raw    (pwm_raw),
    .pwm_hi (bus.pwm_hi),
    .pwm_lo (bus.pwm_lo)
  );
`else
  assign bus.pwm_hi = pwm_raw;
  assign bus.pwm_lo = pwm_act & ~pwm_raw;
`endif
endmodule
